// File: rtl/seg_scan_mux.sv
// Time-multiplexed 4-digit 7-segment driver: refresh prescaler, per-frame
// shadow latching, leading-zero blanking and whole-display blink.
module seg_scan_mux #(
   parameter int          PRESCALE     = 50000,
   parameter int          BLINK_FRAMES = 64,
   parameter logic [6:0]  ZERO_PAT     = 7'b1000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] setm,
   input  logic [6:0] setc,
   input  logic [6:0] setd,
   input  logic [6:0] setu,
   input  logic       lzb,
   input  logic       blink,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       frame
);

   localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
   localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

   logic [PW-1:0] presc;
   logic [1:0]    idx;
   logic [1:0]    nidx;
   logic          tick;
   logic          load;

   // Units has no shadow: its slot is driven only on the load edge itself.
   logic [6:0]    shm, shc, shd;
   logic          bm, bc, bd;
   logic [FW-1:0] fcnt;
   logic          phase;
   logic          fphase;

   logic [6:0]    pat;
   logic          blank;
   logic          vis;
   logic          dark;

   assign tick = (presc == PMAX);
   assign nidx = idx + 2'd1;
   assign load = tick & (idx == 2'd3);

   // Select what the next slot shows; at a frame load the fresh inputs and
   // the pre-toggle phase apply, otherwise the frame's latched copies do.
   always_comb begin
      pat   = 7'h7F;
      blank = 1'b0;
      vis   = fphase;
      case (nidx)
         2'd0: begin
            pat = setu;
            vis = phase;
         end
         2'd1: begin
            pat   = shd;
            blank = bd;
         end
         2'd2: begin
            pat   = shc;
            blank = bc;
         end
         default: begin
            pat   = shm;
            blank = bm;
         end
      endcase
      dark = blank | (blink & ~vis);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shm <= 7'h7F;
         shc <= 7'h7F;
         shd <= 7'h7F;
         bm  <= 1'b0;
         bc  <= 1'b0;
         bd  <= 1'b0;
      end else if (load) begin
         shm <= setm;
         shc <= setc;
         shd <= setd;
         bm  <= lzb & (setm == ZERO_PAT);
         bc  <= lzb & (setm == ZERO_PAT) & (setc == ZERO_PAT);
         bd  <= lzb & (setm == ZERO_PAT) & (setc == ZERO_PAT) & (setd == ZERO_PAT);
      end
   end

   // fphase holds the phase for the whole frame so a toggle never splits one.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fcnt   <= '0;
         phase  <= 1'b1;
         fphase <= 1'b1;
      end else if (load) begin
         fphase <= phase;
         if (fcnt == FMAX) begin
            fcnt  <= '0;
            phase <= ~phase;
         end else begin
            fcnt <= fcnt + FW'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx   <= 2'd3;
         an    <= 4'hF;
         seg   <= 7'h7F;
         frame <= 1'b0;
      end else begin
         frame <= load;
         if (tick) begin
            idx <= nidx;
            an  <= dark ? 4'hF : ~(4'b0001 << nidx);
            seg <= dark ? 7'h7F : pat;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with PRESCALE=4, BLINK_FRAMES=2.
module tb_seg_scan_mux;

   localparam logic [6:0] P0 = 7'b1000000;
   localparam logic [6:0] P1 = 7'b1111001;
   localparam logic [6:0] P2 = 7'b0100100;
   localparam logic [6:0] P3 = 7'b0110000;
   localparam logic [6:0] P4 = 7'b0011001;
   localparam logic [6:0] P5 = 7'b0010010;
   localparam logic [6:0] P7 = 7'b1111000;
   localparam logic [6:0] P9 = 7'b0010000;
   localparam logic [6:0] OFF = 7'b1111111;

   logic       clock = 1'b0;
   logic       reset;
   logic [6:0] setm, setc, setd, setu;
   logic       lzb, blink;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame;

   int n_chk  = 0;
   int n_fail = 0;

   seg_scan_mux #(
      .PRESCALE    (4),
      .BLINK_FRAMES(2),
      .ZERO_PAT    (7'b1000000)
   ) dut (
      .clock(clock),
      .reset(reset),
      .setm (setm),
      .setc (setc),
      .setd (setd),
      .setu (setu),
      .lzb  (lzb),
      .blink(blink),
      .seg  (seg),
      .an   (an),
      .frame(frame)
   );

   always #5 clock = ~clock;

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic slot(input string tag, input logic [3:0] ea, input logic [6:0] es);
      chk({tag, "_an"}, {4'h0, an}, {4'h0, ea});
      chk({tag, "_seg"}, {1'b0, seg}, {1'b0, es});
   endtask

   initial begin
      reset = 1'b1;
      setm = P1; setc = P2; setd = P3; setu = P4;
      lzb = 1'b0; blink = 1'b0;
      step(2);
      slot("rst", 4'b1111, OFF);
      chk("rst_frame", {7'h0, frame}, 8'h0);
      reset = 1'b0;

      // first frame after reset
      step(3);
      slot("pre_first", 4'b1111, OFF);
      step(1);
      slot("f1_units", 4'b1110, P4);
      chk("f1_frame", {7'h0, frame}, 8'h1);
      step(1);
      chk("f1_frame_end", {7'h0, frame}, 8'h0);
      slot("f1_units_hold", 4'b1110, P4);
      step(3);
      slot("f1_tens", 4'b1101, P3);
      setu = P9;
      setm = P5;
      step(4);
      slot("f1_hund", 4'b1011, P2);
      step(4);
      slot("f1_thou_old", 4'b0111, P1);
      step(4);
      slot("f2_units_new", 4'b1110, P9);
      chk("f2_frame", {7'h0, frame}, 8'h1);

      // leading-zero blanking with 0,0,7,0 (loaded at the next frame)
      lzb = 1'b1;
      setm = P0; setc = P0; setd = P7; setu = P0;
      step(4);
      slot("f2_tens_old", 4'b1101, P3);
      step(4);
      slot("f2_hund", 4'b1011, P2);
      step(4);
      slot("f2_thou", 4'b0111, P5);
      step(4);
      slot("lz_units", 4'b1110, P0);
      step(4);
      slot("lz_tens", 4'b1101, P7);
      step(4);
      slot("lz_hund", 4'b1111, OFF);
      step(4);
      slot("lz_thou", 4'b1111, OFF);

      // all zeros: only units lit
      setd = P0;
      step(4);
      slot("z_units", 4'b1110, P0);
      step(4);
      slot("z_tens", 4'b1111, OFF);
      step(4);
      slot("z_hund", 4'b1111, OFF);
      lzb = 1'b0;
      setm = P1; setc = P2; setd = P3; setu = P4;
      step(4);
      slot("z_thou", 4'b1111, OFF);
      step(4);
      slot("r_units", 4'b1110, P4);
      step(4);
      slot("r_tens", 4'b1101, P3);

      // reset mid-slot while tens is lit
      step(1);
      reset = 1'b1;
      #1;
      slot("mid_rst", 4'b1111, OFF);
      @(posedge clock);
      #1;
      reset = 1'b0;
      blink = 1'b1;
      step(3);
      slot("post_rst_dark", 4'b1111, OFF);
      step(1);
      slot("b1_units", 4'b1110, P4);
      chk("b1_frame", {7'h0, frame}, 8'h1);

      // blink: frames 1-2 lit, 3-4 dark, 5-6 lit, 7 dark
      step(12);
      slot("b1_thou", 4'b0111, P1);
      step(4);
      slot("b2_units", 4'b1110, P4);
      step(12);
      slot("b2_thou", 4'b0111, P1);
      step(4);
      slot("b3_units", 4'b1111, OFF);
      chk("b3_frame", {7'h0, frame}, 8'h1);
      step(4);
      slot("b3_tens", 4'b1111, OFF);
      step(12);
      slot("b4_units", 4'b1111, OFF);
      step(12);
      slot("b4_thou", 4'b1111, OFF);
      step(4);
      slot("b5_units", 4'b1110, P4);
      step(16);
      slot("b6_units", 4'b1110, P4);
      step(12);
      slot("b6_thou", 4'b0111, P1);
      step(4);
      slot("b7_units", 4'b1111, OFF);
      blink = 1'b0;
      step(4);
      slot("b7_tens_unblink", 4'b1101, P3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
